// File: rtl/lv_hv_adc_poll.sv
`default_nettype none
// ============================================================================
//  Module   : lv_hv_adc_poll
//  Purpose  : LV-side scheduler that periodically reads the HV ADC shadow
//             register over the one-wire (OWT) link. Sends a read command to
//             the OWT transmitter, waits for the matching OWT receiver frame,
//             handles timeout, error status and bounded retry, and flags good
//             and failed polls.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clk / i_rst_n    clock, asynchronous active-low reset
//    i_poll_en          level, enables periodic polling
//    i_err_clr          pulse, clears o_err_cnt (wins over a same-cycle inc)
//    o_owt_tx_req       read request to OWT tx, held until i_owt_tx_ack
//    o_owt_tx_cmd       {1'b1, ADC_REG_ADDR} while o_owt_tx_req, else 0
//    i_owt_tx_ack       pulse, OWT tx accepted the command
//    i_owt_rx_ack       pulse, OWT rx frame received
//    i_owt_rx_cmd       command field of the received frame
//    i_owt_rx_status    0 = normal, 1 = CRC/parity error
//    o_adc_vld          pulse, good ADC response received
//    o_poll_fail        pulse, retries exhausted
//    o_err_cnt          saturating count of failed polls
//    o_rsp_lat          (LV_HV_POLL_LAT_EN only) tx_ack -> good rx_ack cycles
//    o_busy             1 while a transaction (REQ / WAIT_RSP) is in flight
//  Configuration
//    LV_HV_POLL_LAT_EN  when defined, adds o_rsp_lat and its latency counter
// ============================================================================
module lv_hv_adc_poll #(
  parameter int                OWT_CMD_BIT_NUM = 8,
  parameter int                REG_AW          = 7,
  parameter logic [REG_AW-1:0] ADC_REG_ADDR    = 7'h1F,
  parameter int                POLL_PERIOD_CYC = 1000,
  parameter int                TIMEOUT_CYC     = 200,
  parameter int                MAX_RETRY       = 3,
  parameter int                ERR_CNT_W       = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_poll_en,
  input  logic                       i_err_clr,
  output logic                       o_owt_tx_req,
  output logic [OWT_CMD_BIT_NUM-1:0] o_owt_tx_cmd,
  input  logic                       i_owt_tx_ack,
  input  logic                       i_owt_rx_ack,
  input  logic [OWT_CMD_BIT_NUM-1:0] i_owt_rx_cmd,
  input  logic                       i_owt_rx_status,
  output logic                       o_adc_vld,
  output logic                       o_poll_fail,
  output logic [ERR_CNT_W-1:0]       o_err_cnt,
`ifdef LV_HV_POLL_LAT_EN
  output logic [15:0]                o_rsp_lat,
`endif
  output logic                       o_busy
);

  localparam logic [OWT_CMD_BIT_NUM-1:0] RD_CMD = {1'b1, ADC_REG_ADDR};

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int PER_W = $clog2(POLL_PERIOD_CYC + 1);
  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(POLL_PERIOD_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_REQ         = 2'd1,
    ST_WAIT_RSP    = 2'd2,
    ST_WAIT_PERIOD = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [TMO_W-1:0]     tmo_cnt;
  logic [PER_W-1:0]     per_cnt;
  logic [RTY_W-1:0]     retry_cnt;
  logic                 good_rsp;
  logic                 err_evt;
  logic                 fail_evt;
  logic                 tx_req;
  logic                 busy;
  logic                 adc_vld_q;
  logic                 poll_fail_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    tx_req    = 1'b0;
    busy      = 1'b0;
    good_rsp  = 1'b0;
    err_evt   = 1'b0;
    fail_evt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_poll_en) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        tx_req = 1'b1;
        busy   = 1'b1;
        if (i_owt_tx_ack) state_nxt = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        busy = 1'b1;
        // A received frame always takes priority over a coinciding timeout.
        // A mismatched frame that lands on the timeout cycle defers the
        // timeout by one cycle, hence the >= compare.
        if (i_owt_rx_ack) begin
          if (i_owt_rx_status)            err_evt  = 1'b1;
          else if (i_owt_rx_cmd == RD_CMD) good_rsp = 1'b1;
        end else if (tmo_cnt >= TMO_LAST) begin
          err_evt = 1'b1;
        end
        fail_evt = err_evt && (retry_cnt >= RTY_MAX);
        if (good_rsp || fail_evt) begin
          state_nxt = i_poll_en ? ST_WAIT_PERIOD : ST_IDLE;
        end else if (err_evt) begin
          state_nxt = ST_REQ;
        end
      end
      ST_WAIT_PERIOD: begin
        if (!i_poll_en)              state_nxt = ST_IDLE;
        else if (per_cnt == PER_LAST) state_nxt = ST_REQ;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Timeout, period and retry counters
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_cnt   <= '0;
      per_cnt   <= '0;
      retry_cnt <= '0;
    end else begin
      if (state == ST_WAIT_RSP) begin
        if (tmo_cnt != {TMO_W{1'b1}}) tmo_cnt <= tmo_cnt + TMO_W'(1);
      end else begin
        tmo_cnt <= '0;
      end

      if (state == ST_WAIT_PERIOD && per_cnt != PER_LAST) begin
        per_cnt <= per_cnt + PER_W'(1);
      end else begin
        per_cnt <= '0;
      end

      if (good_rsp || fail_evt) begin
        retry_cnt <= '0;
      end else if (err_evt) begin
        retry_cnt <= retry_cnt + RTY_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered status pulses and failure counter
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      adc_vld_q   <= 1'b0;
      poll_fail_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      adc_vld_q   <= good_rsp;
      poll_fail_q <= fail_evt;
      if (i_err_clr) begin
        err_cnt_q <= '0;
      end else if (fail_evt && err_cnt_q != {ERR_CNT_W{1'b1}}) begin
        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

`ifdef LV_HV_POLL_LAT_EN
  // Loaded with 1 while in REQ so that the value sampled on the good-response
  // edge equals the number of edges since the accepting tx_ack edge.
  logic [15:0] lat_cnt;
  logic [15:0] rsp_lat_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lat_cnt   <= 16'd0;
      rsp_lat_q <= 16'd0;
    end else begin
      if (state == ST_REQ) begin
        lat_cnt <= 16'd1;
      end else if (state == ST_WAIT_RSP && lat_cnt != 16'hFFFF) begin
        lat_cnt <= lat_cnt + 16'd1;
      end
      if (good_rsp) rsp_lat_q <= lat_cnt;
    end
  end

  assign o_rsp_lat = rsp_lat_q;
`endif

  assign o_owt_tx_req = tx_req;
  assign o_owt_tx_cmd = tx_req ? RD_CMD : '0;
  assign o_busy       = busy;
  assign o_adc_vld    = adc_vld_q;
  assign o_poll_fail  = poll_fail_q;
  assign o_err_cnt    = err_cnt_q;

endmodule
`default_nettype wire
